// File: rtl/sram_arbiter.sv
// sram_arbiter: two-port arbiter and cycle sequencer for a 16-bit asynchronous SRAM.
// Port A (CPU) and port B (DMA/video) hold Req until their one-cycle Ack.
// Each access runs IDLE -> SETUP -> ACCESS (WaitStates+1 cycles) -> DONE.
// Optional feature macro: SRAM_ARB_ROUND_ROBIN_EN. When defined, the arbiter is
// round-robin via a LastGrant bit. When undefined, port A has fixed priority.
// All SRAM pins, Acks and the DQ output enable come straight from flops.

module sram_arbiter #(
  parameter int unsigned WaitStates = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        AReq,
  input  logic        BReq,
  input  logic        AWr,
  input  logic        BWr,
  input  logic [19:0] AAddr,
  input  logic [19:0] BAddr,
  input  logic [15:0] AWData,
  input  logic [15:0] BWData,
  input  logic [1:0]  ABe,
  input  logic [1:0]  BBe,
  output logic        AAck,
  output logic        BAck,
  output logic [15:0] ARData,
  output logic [15:0] BRData,
  output logic        CE,
  output logic        OE,
  output logic        WE,
  output logic        LB,
  output logic        UB,
  output logic [19:0] ADDR,
  inout  wire  [15:0] DQ
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_e;

  state_e      state, next_state;
  logic        any_req;
  logic        sel_b;
  logic        cur_b;
  logic        wr_q;
  logic [15:0] wdata_q;
  logic [1:0]  be_q;
  logic [2:0]  cnt;
  logic        dq_oe;

  logic        tx_b;
  logic        tx_wr;
  logic [1:0]  tx_be;

  logic        ce_d, oe_d, we_d, lb_d, ub_d, dq_oe_d, aack_d, back_d;

  assign any_req = AReq | BReq;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  logic last_grant;  // 1 = port B was granted last

  assign sel_b = BReq & (~AReq | ~last_grant);

  // Remember the most recent grant so a tie goes to the other port.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      last_grant <= 1'b1;
    end else if (state == IDLE && any_req) begin
      last_grant <= sel_b;
    end
  end
`else
  assign sel_b = BReq & ~AReq;
`endif

  // Pins are registered from the state being entered, so while still in IDLE
  // the granted port's live inputs stand in for the not-yet-latched copies.
  assign tx_b  = (state == IDLE) ? sel_b : cur_b;
  assign tx_wr = (state == IDLE) ? (sel_b ? BWr : AWr) : wr_q;
  assign tx_be = (state == IDLE) ? (sel_b ? BBe : ABe) : be_q;

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: requests are only looked at in IDLE.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (any_req) next_state = SETUP;
      SETUP:   next_state = ACCESS;
      ACCESS:  if (cnt == '0) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output decode: pin values for the cycle after the coming edge.
  always_comb begin
    ce_d    = 1'b1;
    oe_d    = 1'b1;
    we_d    = 1'b1;
    lb_d    = 1'b1;
    ub_d    = 1'b1;
    dq_oe_d = 1'b0;
    aack_d  = 1'b0;
    back_d  = 1'b0;
    unique case (next_state)
      SETUP: begin
        ce_d    = 1'b0;
        lb_d    = ~tx_be[0];
        ub_d    = ~tx_be[1];
        dq_oe_d = tx_wr;
      end
      ACCESS: begin
        ce_d    = 1'b0;
        lb_d    = ~tx_be[0];
        ub_d    = ~tx_be[1];
        oe_d    = tx_wr;
        we_d    = ~tx_wr;
        dq_oe_d = tx_wr;
      end
      DONE: begin
        ce_d   = 1'b0;
        lb_d   = ~tx_be[0];
        ub_d   = ~tx_be[1];
        aack_d = ~tx_b;
        back_d = tx_b;
      end
      default: ;
    endcase
  end

  // Latch the granted transaction when leaving IDLE.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cur_b   <= 1'b0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      be_q    <= '0;
    end else if (state == IDLE && any_req) begin
      cur_b   <= sel_b;
      wr_q    <= sel_b ? BWr : AWr;
      wdata_q <= sel_b ? BWData : AWData;
      be_q    <= sel_b ? BBe : ABe;
    end
  end

  // Wait-state down-counter, loaded in SETUP and run down through ACCESS.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt <= '0;
    end else if (state == SETUP) begin
      cnt <= 3'(WaitStates);
    end else if (state == ACCESS && cnt != '0) begin
      cnt <= cnt - 3'd1;
    end
  end

  // Registered SRAM controls, address, DQ enable and Acks.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      CE    <= 1'b1;
      OE    <= 1'b1;
      WE    <= 1'b1;
      LB    <= 1'b1;
      UB    <= 1'b1;
      ADDR  <= '0;
      dq_oe <= 1'b0;
      AAck  <= 1'b0;
      BAck  <= 1'b0;
    end else begin
      CE    <= ce_d;
      OE    <= oe_d;
      WE    <= we_d;
      LB    <= lb_d;
      UB    <= ub_d;
      dq_oe <= dq_oe_d;
      AAck  <= aack_d;
      BAck  <= back_d;
      if (state == IDLE && any_req) begin
        ADDR <= sel_b ? BAddr : AAddr;
      end
    end
  end

  // Capture read data on the last ACCESS cycle into the granted port.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      ARData <= '0;
      BRData <= '0;
    end else if (state == ACCESS && cnt == '0 && !wr_q) begin
      if (cur_b) begin
        BRData <= DQ;
      end else begin
        ARData <= DQ;
      end
    end
  end

  assign DQ = dq_oe ? wdata_q : 'z;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: lane 0 runs WaitStates=1, lane 1 runs WaitStates=0.
// Each lane has its own SRAM array and a phase-counting transaction model
// compared against the DUT every cycle; directed scenarios add literal checks.

module tb_sram_arbiter;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic [1:0]  rst;
  logic [1:0]  areq, breq, awr, bwr;
  logic [19:0] aaddr [2];
  logic [19:0] baddr [2];
  logic [15:0] awd [2];
  logic [15:0] bwd [2];
  logic [1:0]  abe [2];
  logic [1:0]  bbe [2];

  wire  [1:0]  aack, back, ce_o, oe_o, we_o, lb_o, ub_o;
  wire  [19:0] addr_o [2];
  wire  [15:0] ard [2];
  wire  [15:0] brd [2];

  int   n_cmp = 0;
  int   n_bad = 0;
  logic chk_en = 1'b0;

  int          oe_lo = 0;
  logic [1:0]  lbub = 2'b11;
  logic [31:0] ack_bits = '0;
  int          ack_n = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int WS = (g == 0) ? 1 : 0;

    wire  [15:0] dq;
    logic [15:0] mem [64];

    logic        m_act  = 1'b0;
    int          m_t    = 0;
    logic        m_b    = 1'b0;
    logic        m_wr   = 1'b0;
    logic [19:0] m_addr = '0;
    logic [15:0] m_wd   = '0;
    logic [1:0]  m_be   = '0;
    logic [19:0] e_addr = '0;
    logic [15:0] e_ard  = '0;
    logic [15:0] e_brd  = '0;
    wire         gnt_b;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    logic m_last = 1'b1;
    assign gnt_b = breq[g] & (~areq[g] | ~m_last);
`else
    assign gnt_b = breq[g] & ~areq[g];
`endif

    sram_arbiter #(.WaitStates(WS)) u_dut (
      .Clk    (Clk),
      .Reset  (rst[g]),
      .AReq   (areq[g]),
      .BReq   (breq[g]),
      .AWr    (awr[g]),
      .BWr    (bwr[g]),
      .AAddr  (aaddr[g]),
      .BAddr  (baddr[g]),
      .AWData (awd[g]),
      .BWData (bwd[g]),
      .ABe    (abe[g]),
      .BBe    (bbe[g]),
      .AAck   (aack[g]),
      .BAck   (back[g]),
      .ARData (ard[g]),
      .BRData (brd[g]),
      .CE     (ce_o[g]),
      .OE     (oe_o[g]),
      .WE     (we_o[g]),
      .LB     (lb_o[g]),
      .UB     (ub_o[g]),
      .ADDR   (addr_o[g]),
      .DQ     (dq)
    );

    // Asynchronous SRAM: drives DQ whenever chip and output are enabled for a read.
    assign dq = (!ce_o[g] && !oe_o[g] && we_o[g]) ? mem[addr_o[g][5:0]] : 'z;

    initial begin
      for (int i = 0; i < 64; i++) mem[i] = 16'hC000 + 16'(i);
      mem[1]  = 16'h1111;
      mem[2]  = 16'h2222;
      mem[3]  = 16'h3333;
      mem[5]  = 16'h1234;
      mem[16] = 16'hFFFF;
    end

    always @(posedge Clk) begin
      if (!ce_o[g] && !we_o[g]) begin
        if (!lb_o[g]) mem[addr_o[g][5:0]][7:0]  <= dq[7:0];
        if (!ub_o[g]) mem[addr_o[g][5:0]][15:8] <= dq[15:8];
      end
    end

    // Model: a grant at edge n puts phase 1 (SETUP) in the next cycle,
    // phases 2..WS+2 are the strobe, phase WS+3 is the Ack cycle.
    always @(posedge Clk) begin
      if (rst[g]) begin
        m_act  <= 1'b0;
        e_addr <= '0;
        e_ard  <= '0;
        e_brd  <= '0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        m_last <= 1'b1;
`endif
      end else if (m_act) begin
        if (m_t == WS + 2 && !m_wr) begin
          if (m_b) e_brd <= mem[m_addr[5:0]];
          else     e_ard <= mem[m_addr[5:0]];
        end
        if (m_t == WS + 3) m_act <= 1'b0;
        else               m_t   <= m_t + 1;
      end else if (areq[g] || breq[g]) begin
        m_act  <= 1'b1;
        m_t    <= 1;
        m_b    <= gnt_b;
        m_wr   <= gnt_b ? bwr[g] : awr[g];
        m_addr <= gnt_b ? baddr[g] : aaddr[g];
        e_addr <= gnt_b ? baddr[g] : aaddr[g];
        m_wd   <= gnt_b ? bwd[g] : awd[g];
        m_be   <= gnt_b ? bbe[g] : abe[g];
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        m_last <= gnt_b;
`endif
      end
    end

    wire       strobe = m_act && (m_t >= 2) && (m_t <= WS + 2);
    wire       e_drv  = m_act && m_wr && (m_t <= WS + 2);
    wire       e_ack  = m_act && (m_t == WS + 3);
    wire [6:0] e_pins = {~m_act,
                         ~(strobe && !m_wr),
                         ~(strobe && m_wr),
                         m_act ? ~m_be[0] : 1'b1,
                         m_act ? ~m_be[1] : 1'b1,
                         e_ack && !m_b,
                         e_ack && m_b};

    always @(negedge Clk) begin
      if (chk_en) begin
        check($sformatf("pins%0d", g),
              32'({ce_o[g], oe_o[g], we_o[g], lb_o[g], ub_o[g], aack[g], back[g]}),
              32'(e_pins));
        check($sformatf("addr%0d", g), 32'(addr_o[g]), 32'(e_addr));
        check($sformatf("ardata%0d", g), 32'(ard[g]), 32'(e_ard));
        check($sformatf("brdata%0d", g), 32'(brd[g]), 32'(e_brd));
        check($sformatf("dq_oe%0d", g), 32'(u_dut.dq_oe), 32'(e_drv));
        if (e_drv) check($sformatf("dq_wr%0d", g), 32'(dq), 32'(m_wd));
        if (strobe && !m_wr) check($sformatf("dq_rd%0d", g), 32'(dq), 32'(mem[m_addr[5:0]]));
      end
    end
  end

  // Lane-0 observers used by the directed scenarios.
  always @(negedge Clk) begin
    if (!oe_o[0]) oe_lo <= oe_lo + 1;
    if (!ce_o[0]) lbub <= {lb_o[0], ub_o[0]};
    if (aack[0] || back[0]) begin
      ack_bits <= {ack_bits[30:0], back[0]};
      ack_n    <= ack_n + 1;
    end
  end

  // Runs n back-to-back transactions on one port; a follow-on transaction is
  // presented in the Ack cycle so Req stays high into the next IDLE.
  task automatic run_port(input int ln, input bit pb, input int n, input bit wr,
                          input logic [19:0] a0, input logic [15:0] d0, input logic [1:0] be,
                          output int lat, output int gap,
                          output logic [15:0] rd_first, output logic [15:0] rd_last);
    int t = 0;
    int prev = 0;
    lat = -1; gap = -1; rd_first = '0; rd_last = '0;
    @(negedge Clk);
    for (int i = 0; i < n; i++) begin
      if (pb) begin
        breq[ln] = 1'b1; bwr[ln] = wr; baddr[ln] = a0 + 20'(i);
        bwd[ln] = d0 + 16'(i); bbe[ln] = be;
      end else begin
        areq[ln] = 1'b1; awr[ln] = wr; aaddr[ln] = a0 + 20'(i);
        awd[ln] = d0 + 16'(i); abe[ln] = be;
      end
      begin : wait_ack
        for (int k = 0; k < 100; k++) begin
          @(negedge Clk);
          t++;
          if (pb ? back[ln] : aack[ln]) disable wait_ack;
        end
        check("ack_timeout", 32'(t), 32'hFFFF_FFFF);
        if (pb) breq[ln] = 1'b0; else areq[ln] = 1'b0;
        return;
      end
      if (i == 0) begin
        lat = t;
        rd_first = pb ? brd[ln] : ard[ln];
      end else begin
        gap = t - prev;
      end
      prev = t;
      rd_last = pb ? brd[ln] : ard[ln];
    end
    if (pb) breq[ln] = 1'b0; else areq[ln] = 1'b0;
  endtask

  initial begin
    int lat, gap, lat2, gap2, s0;
    logic [15:0] r0, r1, r2, r3;

    rst = 2'b11; areq = '0; breq = '0; awr = '0; bwr = '0;
    for (int i = 0; i < 2; i++) begin
      aaddr[i] = '0; baddr[i] = '0; awd[i] = '0; bwd[i] = '0; abe[i] = '0; bbe[i] = '0;
    end
    @(negedge Clk);
    chk_en = 1'b1;
    @(negedge Clk);
    check("rst_pins", 32'({ce_o[0], oe_o[0], we_o[0], lb_o[0], ub_o[0]}), 32'h1F);
    check("rst_addr", 32'(addr_o[0]), 32'h0);
    check("rst_acks", 32'({aack, back}), 32'h0);
    check("rst_rdata", 32'({ard[0], brd[0]}), 32'h0);
    rst = 2'b00;

    // Single read from A, word 5.
    s0 = oe_lo;
    run_port(0, 1'b0, 1, 1'b0, 20'h00005, 16'h0000, 2'b11, lat, gap, r0, r1);
    check("rd_a_latency", 32'(lat), 32'd4);
    check("rd_a_data", 32'(r0), 32'h1234);
    check("rd_a_oe_cycles", 32'(oe_lo - s0), 32'd2);

    // Lower-byte write from B to word 16, then read it back through A.
    run_port(0, 1'b1, 1, 1'b1, 20'h00010, 16'hABCD, 2'b01, lat, gap, r0, r1);
    check("wr_b_lb_ub", 32'(lbub), 32'b01);
    check("wr_b_latency", 32'(lat), 32'd4);
    run_port(0, 1'b0, 1, 1'b0, 20'h00010, 16'h0000, 2'b11, lat, gap, r0, r1);
    check("wr_b_readback", 32'(r0), 32'hFFCD);

    // Both ports held for three transactions each, from a fresh reset.
    rst[0] = 1'b1;
    @(negedge Clk);
    rst[0] = 1'b0;
    s0 = ack_n;
    fork
      run_port(0, 1'b0, 3, 1'b0, 20'h00001, 16'h0000, 2'b11, lat, gap, r0, r1);
      run_port(0, 1'b1, 3, 1'b1, 20'h00020, 16'h5000, 2'b11, lat2, gap2, r2, r3);
    join
    @(negedge Clk);
    check("tie_ack_count", 32'(ack_n - s0), 32'd6);
    check("tie_a_latency", 32'(lat), 32'd4);
    check("tie_a_last_data", 32'(r1), 32'h3333);
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    check("tie_order", 32'(ack_bits[5:0]), 32'b010101);
    check("tie_a_gap", 32'(gap), 32'd10);
    check("tie_b_latency", 32'(lat2), 32'd9);
`else
    check("tie_order", 32'(ack_bits[5:0]), 32'b000111);
    check("tie_a_gap", 32'(gap), 32'd5);
    check("tie_b_latency", 32'(lat2), 32'd19);
`endif
    check("tie_b_gap", 32'(gap2), 32'd5 * 32'(1 + (ack_bits[4] ? 1 : 0)));

    // WaitStates=0 lane: back-to-back reads of words 1 and 2.
    run_port(1, 1'b0, 2, 1'b0, 20'h00001, 16'h0000, 2'b11, lat, gap, r0, r1);
    check("ws0_latency", 32'(lat), 32'd3);
    check("ws0_gap", 32'(gap), 32'd4);
    check("ws0_data1", 32'(r0), 32'h1111);
    check("ws0_data2", 32'(r1), 32'h2222);

    // Reset in the middle of a write strobe.
    @(negedge Clk);
    breq[0] = 1'b1; bwr[0] = 1'b1; baddr[0] = 20'h00014; bwd[0] = 16'h5555; bbe[0] = 2'b11;
    @(negedge Clk);
    @(negedge Clk);
    check("abort_in_access", 32'({ce_o[0], we_o[0]}), 32'b00);
    rst[0] = 1'b1;
    breq[0] = 1'b0;
    @(negedge Clk);
    rst[0] = 1'b0;
    check("abort_ce_we", 32'({ce_o[0], we_o[0]}), 32'b11);
    check("abort_dq_oe", 32'(lane[0].u_dut.dq_oe), 32'h0);
    s0 = ack_n;
    repeat (6) @(negedge Clk);
    check("abort_no_ack", 32'(ack_n - s0), 32'd0);
    run_port(0, 1'b0, 1, 1'b0, 20'h00005, 16'h0000, 2'b11, lat, gap, r0, r1);
    check("after_abort_latency", 32'(lat), 32'd4);
    check("after_abort_data", 32'(r0), 32'h1234);

    repeat (3) @(negedge Clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
